// File: rtl/radar_sched_pkg.sv
// rtl/radar_sched_pkg.sv - shared types and constants for the radar ping scheduler
//
// Purpose: scheduler state encoding, distance width/limit and the saturating
//          distance helper used by radar_ping_scheduler.
// Ports:   none (package).

package radar_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_TRIGGER = 3'd1,
    S_LISTEN  = 3'd2,
    S_REPORT  = 3'd3,
    S_GUARD   = 3'd4
  } sched_state_t;

  localparam int DIST_W   = 14;
  localparam int DIST_MAX = 16383;
  localparam int MULT_W   = 24;

  // Clamp a wide cycles*metres product into the distance output range.
  function automatic logic [DIST_W-1:0] sat_dist(input logic [MULT_W-1:0] prod);
    if (prod > MULT_W'(DIST_MAX)) begin
      return DIST_W'(DIST_MAX);
    end
    return prod[DIST_W-1:0];
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick for the ping scheduler
//
// Purpose: selects the lowest requesting index at or above ptr, wrapping
//          around. Holds no state; the pointer lives in the parent.
// Ports:
//   req        in  N_REQ  request vector
//   ptr        in  ID_W   search start index
//   gnt_onehot out N_REQ  one-hot winner (0 when no request)
//   gnt_idx    out ID_W   winner index (0 when no request)
//   gnt_any    out 1      at least one request present

module rr_arbiter #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] ptr,
  output logic [N_REQ-1:0]         gnt_onehot,
  output logic [$clog2(N_REQ)-1:0] gnt_idx,
  output logic                     gnt_any
);

  localparam int ID_W = $clog2(N_REQ);

  logic [ID_W-1:0] sel;

  always_comb begin
    gnt_onehot = '0;
    gnt_idx    = '0;
    gnt_any    = 1'b0;
    sel        = '0;
    // Walk outward from ptr; the first hit wins and later hits are masked.
    for (int off = 0; off < N_REQ; off++) begin
      sel = ID_W'((int'(ptr) + off) % N_REQ);
      if (!gnt_any && req[sel]) begin
        gnt_any         = 1'b1;
        gnt_idx         = sel;
        gnt_onehot[sel] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/radar_ping_scheduler.sv
// rtl/radar_ping_scheduler.sv - round-robin time-sharing of one radar TX/RX pair
//
// Purpose: grants one requester per ping, pulses the transmitter, counts echo
//          delay, converts it to a saturating distance and reports it tagged
//          with the requester index.
// Optional feature: define RADAR_PING_STATS_EN to add ping/miss counters.
// Ports:
//   clk                       in  1      system clock
//   rst                       in  1      asynchronous active-low reset
//   req                       in  N_REQ  per-requester ping request (level)
//   radar_echo                in  1      echo detect (only used while listening)
//   grant                     out N_REQ  one-hot owner of the current ping
//   trigger_radar_transmitter out 1      single-cycle transmit pulse
//   distance_to_target        out 14     metres, saturating, held until next result
//   result_valid              out 1      single-cycle result strobe
//   result_hit                out 1      1 = echo, 0 = timeout
//   result_id                 out ID_W   requester index of the result
//   sched_state               out 3      FSM state for debug
//   pings_total               out 16     (RADAR_PING_STATS_EN) results reported
//   misses_total              out 16     (RADAR_PING_STATS_EN) timeouts reported

module radar_ping_scheduler
  import radar_sched_pkg::*;
#(
  parameter int N_REQ            = 4,
  parameter int METERS_PER_CYCLE = 1500,
  parameter int TIMEOUT_CYCLES   = 20,
  parameter int GUARD_CYCLES     = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic                     radar_echo,
  output logic [N_REQ-1:0]         grant,
  output logic                     trigger_radar_transmitter,
  output logic [13:0]              distance_to_target,
  output logic                     result_valid,
  output logic                     result_hit,
  output logic [$clog2(N_REQ)-1:0] result_id,
`ifdef RADAR_PING_STATS_EN
  output logic [15:0]              pings_total,
  output logic [15:0]              misses_total,
`endif
  output logic [2:0]               sched_state
);

  localparam int ID_W = $clog2(N_REQ);

  sched_state_t      state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]   owner_q, owner_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [N_REQ-1:0]  grant_q, grant_d;
  logic              trig_q, trig_d;
  logic              valid_q, valid_d;
  logic [DIST_W-1:0] dist_q, dist_d;
  logic              hit_q, hit_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [MULT_W-1:0] prod;

  logic [N_REQ-1:0]  arb_onehot;
  logic [ID_W-1:0]   arb_idx;
  logic              arb_any;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req        (req),
    .ptr        (rr_ptr_q),
    .gnt_onehot (arb_onehot),
    .gnt_idx    (arb_idx),
    .gnt_any    (arb_any)
  );

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    cnt_d    = cnt_q;
    grant_d  = grant_q;
    trig_d   = 1'b0;
    valid_d  = 1'b0;
    dist_d   = dist_q;
    hit_d    = hit_q;
    id_d     = id_q;
    prod     = MULT_W'(cnt_q) * MULT_W'(METERS_PER_CYCLE);

    case (state_q)
      S_IDLE: begin
        if (arb_any) begin
          state_d  = S_TRIGGER;
          grant_d  = arb_onehot;
          trig_d   = 1'b1;
          owner_d  = arb_idx;
          cnt_d    = '0;
          rr_ptr_d = (arb_idx == ID_W'(N_REQ - 1)) ? '0 : arb_idx + ID_W'(1);
        end
      end
      S_TRIGGER: begin
        state_d = S_LISTEN;
        cnt_d   = cnt_q + 8'd1;
      end
      S_LISTEN: begin
        // Echo is checked first so it wins over a coincident timeout.
        if (radar_echo) begin
          state_d = S_REPORT;
          valid_d = 1'b1;
          hit_d   = 1'b1;
          dist_d  = sat_dist(prod);
          id_d    = owner_q;
        end else if (cnt_q == 8'(TIMEOUT_CYCLES)) begin
          state_d = S_REPORT;
          valid_d = 1'b1;
          hit_d   = 1'b0;
          dist_d  = '0;
          id_d    = owner_q;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_REPORT: begin
        grant_d = '0;
        if (GUARD_CYCLES == 0) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_GUARD;
          cnt_d   = 8'd1;
        end
      end
      S_GUARD: begin
        if (cnt_q >= 8'(GUARD_CYCLES)) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      cnt_q    <= '0;
      grant_q  <= '0;
      trig_q   <= 1'b0;
      valid_q  <= 1'b0;
      dist_q   <= '0;
      hit_q    <= 1'b0;
      id_q     <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
      grant_q  <= grant_d;
      trig_q   <= trig_d;
      valid_q  <= valid_d;
      dist_q   <= dist_d;
      hit_q    <= hit_d;
      id_q     <= id_d;
    end
  end

`ifdef RADAR_PING_STATS_EN
  logic [15:0] pings_q, pings_d;
  logic [15:0] misses_q, misses_d;

  always_comb begin
    pings_d  = pings_q;
    misses_d = misses_q;
    // valid_d marks the edge that enters REPORT with a fresh result.
    if (valid_d) begin
      if (pings_q != 16'hFFFF) pings_d = pings_q + 16'd1;
      if (!hit_d && misses_q != 16'hFFFF) misses_d = misses_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pings_q  <= '0;
      misses_q <= '0;
    end else begin
      pings_q  <= pings_d;
      misses_q <= misses_d;
    end
  end

  assign pings_total  = pings_q;
  assign misses_total = misses_q;
`endif

  assign grant                     = grant_q;
  assign trigger_radar_transmitter = trig_q;
  assign distance_to_target        = dist_q;
  assign result_valid              = valid_q;
  assign result_hit                = hit_q;
  assign result_id                 = id_q;
  assign sched_state               = state_q;

endmodule
